m2_sram_port_arbiter: RTL and testbench

//  Shares the single external SRAM port between the S' fetch unit (read requester RD) and the
//  S write-back unit (write requester WR), so fetch of block n+1 overlaps write-back of block n.

---
 rtl/m2_sram_port_arbiter_pkg.sv | 23 ++
 rtl/m2_sram_port_arbiter_read_return_pipe.sv | 41 ++++
 rtl/m2_sram_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_m2_sram_port_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/m2_sram_port_arbiter_pkg.sv
// ============================================================================
// Module : m2_sram_port_arbiter_pkg
// Brief  : Shared Milestone 2 types and widths for the SRAM port arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package m2_sram_port_arbiter_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    // M2 arbiter state definitions
    typedef enum logic [1:0] {
        S_ARB_IDLE = 2'd0,
        S_ARB_RD   = 2'd1,
        S_ARB_WR   = 2'd2,
        S_ARB_TURN = 2'd3
    } arb_state_type;

endpackage

`default_nettype wire

// File: rtl/m2_sram_port_arbiter_read_return_pipe.sv
// ============================================================================
// Module : sram_read_return_pipe
// Brief  : Delays each read grant by DEPTH cycles to mark returning SRAM data.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_read_return_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_gnt,
    output logic o_valid
);

    logic [DEPTH-1:0] pipe_q;
    logic [DEPTH-1:0] pipe_d;

    generate
        if (DEPTH == 1) begin : g_single
            always_comb pipe_d = i_gnt;
        end else begin : g_shift
            always_comb pipe_d = {pipe_q[DEPTH-2:0], i_gnt};
        end
    endgenerate

    // Async clear drops any reads still in flight when reset hits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign o_valid = pipe_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/m2_sram_port_arbiter.sv
// ============================================================================
// Module : m2_sram_port_arbiter
// Brief  : Round-robin bounded-burst sharing of one SRAM port between fetch
//          (read) and write-back (write), with a write->read turnaround bubble.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module m2_sram_port_arbiter
    import m2_sram_port_arbiter_pkg::*;
#(
    parameter int BURST_MAX    = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic                   CLOCK_50_I,
    input  logic                   Reset,
    input  logic                   rd_req,
    input  logic [SRAM_ADDR_W-1:0] rd_address,
    output logic                   rd_gnt,
    output logic [SRAM_DATA_W-1:0] rd_data,
    output logic                   rd_data_valid,
    input  logic                   wr_req,
    input  logic [SRAM_ADDR_W-1:0] wr_address,
    input  logic [SRAM_DATA_W-1:0] wr_data,
    output logic                   wr_gnt,
    output logic [SRAM_ADDR_W-1:0] SRAM_address,
    output logic [SRAM_DATA_W-1:0] SRAM_write_data,
    output logic                   SRAM_we_n,
    input  logic [SRAM_DATA_W-1:0] SRAM_read_data
);

    localparam int                CNT_W      = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] c_BURST_MAX = CNT_W'(BURST_MAX);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

    arb_state_type    state_q,         state_d;
    logic [CNT_W-1:0] burst_cnt_q,     burst_cnt_d;
    logic             last_owner_wr_q, last_owner_wr_d;

    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_leave;

    always_comb begin
        state_d         = state_q;
        burst_cnt_d     = burst_cnt_q;
        last_owner_wr_d = last_owner_wr_q;
        rd_gnt          = 1'b0;
        wr_gnt          = 1'b0;
        w_cnt_inc       = burst_cnt_q;
        w_leave         = 1'b0;

        case (state_q)
            S_ARB_IDLE: begin
                burst_cnt_d = '0;
                // On a tie the requester that did not own the port last wins.
                if (rd_req && wr_req) begin
                    state_d = last_owner_wr_q ? S_ARB_RD : S_ARB_WR;
                end else if (rd_req) begin
                    state_d = S_ARB_RD;
                end else if (wr_req) begin
                    state_d = S_ARB_WR;
                end
            end

            S_ARB_RD: begin
                rd_gnt = rd_req;
                if (rd_req && (burst_cnt_q != c_BURST_MAX)) begin
                    w_cnt_inc = burst_cnt_q + c_CNT_ONE;
                end
                w_leave     = !rd_req || ((w_cnt_inc == c_BURST_MAX) && wr_req);
                burst_cnt_d = w_cnt_inc;
                if (w_leave) begin
                    last_owner_wr_d = 1'b0;
                    burst_cnt_d     = '0;
                    state_d         = wr_req ? S_ARB_WR : S_ARB_IDLE;
                end
            end

            S_ARB_WR: begin
                wr_gnt = wr_req;
                if (wr_req && (burst_cnt_q != c_BURST_MAX)) begin
                    w_cnt_inc = burst_cnt_q + c_CNT_ONE;
                end
                w_leave     = !wr_req || ((w_cnt_inc == c_BURST_MAX) && rd_req);
                burst_cnt_d = w_cnt_inc;
                if (w_leave) begin
                    last_owner_wr_d = 1'b1;
                    burst_cnt_d     = '0;
                    // Handing the port to reads always costs one bubble cycle.
                    state_d         = rd_req ? S_ARB_TURN : S_ARB_IDLE;
                end
            end

            S_ARB_TURN: begin
                burst_cnt_d = '0;
                state_d     = S_ARB_RD;
            end

            default: begin
                burst_cnt_d = '0;
                state_d     = S_ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50_I or posedge Reset) begin
        if (Reset) begin
            state_q         <= S_ARB_IDLE;
            burst_cnt_q     <= '0;
            last_owner_wr_q <= 1'b1;
        end else begin
            state_q         <= state_d;
            burst_cnt_q     <= burst_cnt_d;
            last_owner_wr_q <= last_owner_wr_d;
        end
    end

    // The port is driven only by an actual grant; otherwise it idles at zero/read.
    always_comb begin
        SRAM_address    = '0;
        SRAM_write_data = '0;
        SRAM_we_n       = 1'b1;
        if (rd_gnt) begin
            SRAM_address = rd_address;
        end else if (wr_gnt) begin
            SRAM_address    = wr_address;
            SRAM_write_data = wr_data;
            SRAM_we_n       = 1'b0;
        end
    end

    sram_read_return_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_read_return_pipe (
        .clk     (CLOCK_50_I),
        .rst     (Reset),
        .i_gnt   (rd_gnt),
        .o_valid (rd_data_valid)
    );

    assign rd_data = rd_data_valid ? SRAM_read_data : '0;

endmodule

`default_nettype wire

// File: tb/tb_m2_sram_port_arbiter.sv
// ============================================================================
// Module : tb_m2_sram_port_arbiter
// Brief  : Directed and randomized bench for m2_sram_port_arbiter against an
//          owner/run-length reference model with a read-return due queue.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_m2_sram_port_arbiter;
    import m2_sram_port_arbiter_pkg::*;

    localparam int BMAX = 8;
    localparam int LAT  = 2;

    logic                   clk = 1'b0;
    logic                   Reset;
    logic                   rd_req;
    logic [SRAM_ADDR_W-1:0] rd_address;
    logic                   rd_gnt;
    logic [SRAM_DATA_W-1:0] rd_data;
    logic                   rd_data_valid;
    logic                   wr_req;
    logic [SRAM_ADDR_W-1:0] wr_address;
    logic [SRAM_DATA_W-1:0] wr_data;
    logic                   wr_gnt;
    logic [SRAM_ADDR_W-1:0] SRAM_address;
    logic [SRAM_DATA_W-1:0] SRAM_write_data;
    logic                   SRAM_we_n;
    logic [SRAM_DATA_W-1:0] SRAM_read_data;

    always #5 clk = ~clk;

    m2_sram_port_arbiter #(
        .BURST_MAX    (BMAX),
        .READ_LATENCY (LAT)
    ) dut (
        .CLOCK_50_I      (clk),
        .Reset           (Reset),
        .rd_req          (rd_req),
        .rd_address      (rd_address),
        .rd_gnt          (rd_gnt),
        .rd_data         (rd_data),
        .rd_data_valid   (rd_data_valid),
        .wr_req          (wr_req),
        .wr_address      (wr_address),
        .wr_data         (wr_data),
        .wr_gnt          (wr_gnt),
        .SRAM_address    (SRAM_address),
        .SRAM_write_data (SRAM_write_data),
        .SRAM_we_n       (SRAM_we_n),
        .SRAM_read_data  (SRAM_read_data)
    );

    int total  = 0;
    int passed = 0;
    int cyc    = 0;

    // Reference model: who owns the port (0 none, 1 reader, 2 writer,
    // 3 bubble before reader), grants so far in this run, and who owned last.
    int owner   = 0;
    int run     = 0;
    bit rd_last = 1'b0;
    int due_q[$];

    bit e_rd, e_wr, e_valid;
    int n_rdg = 0, n_wrg = 0, n_val = 0;
    bit last_rd_gnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) passed++;
        else $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, want, cyc);
    endtask

    task automatic model_commit();
        bit mine, other;
        if (Reset) begin
            due_q.delete();
            owner   = 0;
            run     = 0;
            rd_last = 1'b0;
            return;
        end
        if (e_valid) void'(due_q.pop_front());
        if (e_rd) due_q.push_back(cyc + LAT);
        case (owner)
            0: begin
                run = 0;
                if (rd_req && wr_req) owner = rd_last ? 2 : 1;
                else if (rd_req)      owner = 1;
                else if (wr_req)      owner = 2;
            end
            3: begin
                run   = 0;
                owner = 1;
            end
            default: begin
                mine  = (owner == 1) ? rd_req : wr_req;
                other = (owner == 1) ? wr_req : rd_req;
                if (mine && run < BMAX) run = run + 1;
                if (!mine || (run == BMAX && other)) begin
                    rd_last = (owner == 1);
                    run     = 0;
                    if (!other)          owner = 0;
                    else if (owner == 1) owner = 2;
                    else                 owner = 3;
                end
            end
        endcase
    endtask

    // Inputs are set just after a rising edge; outputs are compared on the falling edge.
    task automatic tick();
        SRAM_read_data = SRAM_DATA_W'($urandom);
        @(negedge clk);
        e_rd    = !Reset && (owner == 1) && rd_req;
        e_wr    = !Reset && (owner == 2) && wr_req;
        e_valid = !Reset && (due_q.size() > 0) && (due_q[0] == cyc);
        chk("rd_gnt",    32'(rd_gnt),          32'(e_rd));
        chk("wr_gnt",    32'(wr_gnt),          32'(e_wr));
        chk("we_n",      32'(SRAM_we_n),       32'(!e_wr));
        chk("address",   32'(SRAM_address),
            e_rd ? 32'(rd_address) : (e_wr ? 32'(wr_address) : 32'd0));
        chk("wdata",     32'(SRAM_write_data), e_wr ? 32'(wr_data) : 32'd0);
        chk("rd_valid",  32'(rd_data_valid),   32'(e_valid));
        chk("rd_data",   32'(rd_data),         e_valid ? 32'(SRAM_read_data) : 32'd0);
        n_rdg += int'(rd_gnt);
        n_wrg += int'(wr_gnt);
        n_val += int'(rd_data_valid);
        last_rd_gnt = rd_gnt;
        @(posedge clk);
        model_commit();
        cyc++;
        #1;
    endtask

    task automatic clr_counts();
        n_rdg = 0;
        n_wrg = 0;
        n_val = 0;
    endtask

    initial begin
        Reset = 1'b1; rd_req = 1'b1; wr_req = 1'b1;
        rd_address = '0; wr_address = '0; wr_data = '0; SRAM_read_data = '0;
        #1;

        // Reset held with both requesting: nothing granted.
        repeat (3) tick();
        Reset = 1'b0;
        tick();
        clr_counts();
        // Tie after reset, then 8 RD, 8 WR, bubble, 8 RD.
        repeat (25) tick();
        chk("pattern_rd_grants", 32'(n_rdg), 32'd16);
        chk("pattern_wr_grants", 32'(n_wrg), 32'd8);
        rd_req = 1'b0; wr_req = 1'b0;
        repeat (4) tick();

        // Read-only stream of 20 back-to-back reads.
        rd_req = 1'b1; rd_address = 18'h00100;
        tick();
        clr_counts();
        for (int i = 0; i < 20; i++) begin
            tick();
            rd_address = rd_address + 18'd1;
        end
        rd_req = 1'b0;
        repeat (3) tick();
        chk("stream_grants", 32'(n_rdg), 32'd20);
        chk("stream_returns", 32'(n_val), 32'd20);

        // Single write at the top of the address space.
        wr_req = 1'b1; wr_address = 18'h3FFFF; wr_data = 16'hBEEF;
        repeat (2) tick();
        wr_req = 1'b0;
        repeat (2) tick();

        // RD owner with 3 grants, then rd drops while wr rises.
        rd_req = 1'b1;
        tick();
        clr_counts();
        repeat (3) tick();
        rd_req = 1'b0; wr_req = 1'b1; wr_address = 18'h01234; wr_data = 16'h5A5A;
        repeat (2) tick();
        wr_req = 1'b0;
        repeat (3) tick();
        chk("switch_returns", 32'(n_val), 32'd3);
        chk("switch_wr_grants", 32'(n_wrg), 32'd1);

        // Reset with two reads in flight; then tie goes to RD.
        rd_req = 1'b1;
        repeat (3) tick();
        Reset = 1'b1; wr_req = 1'b1;
        clr_counts();
        repeat (3) tick();
        Reset = 1'b0;
        repeat (3) tick();
        chk("reset_drop_returns", 32'(n_val), 32'd0);
        chk("post_reset_rd_first", 32'(last_rd_gnt), 32'd1);
        chk("post_reset_no_wr", 32'(n_wrg), 32'd0);
        rd_req = 1'b0; wr_req = 1'b0;
        repeat (3) tick();

        // Randomized traffic; a requester holds until it is granted.
        for (int i = 0; i < 1500; i++) begin
            if (!(rd_req && !e_rd)) begin
                rd_req     = ($urandom_range(0, 3) != 0);
                rd_address = SRAM_ADDR_W'($urandom);
            end
            if (!(wr_req && !e_wr)) begin
                wr_req     = ($urandom_range(0, 2) != 0);
                wr_address = SRAM_ADDR_W'($urandom);
                wr_data    = SRAM_DATA_W'($urandom);
            end
            if (i % 40 == 39) begin
                rd_req = 1'b0;
                wr_req = 1'b0;
            end
            Reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        Reset = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
        repeat (4) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
